// File: rtl/aes_enc_round_if.sv
// Handshake/data bundle between the AES round sequencer (master) and one
// encryption round (slave).
interface aes_enc_round_if;
   logic         in_valid;
   logic [127:0] state_in;
   logic [127:0] round_key;
   logic         is_last_round;
   logic         out_valid;
   logic [127:0] state_out;

   modport master (
      output in_valid,
      output state_in,
      output round_key,
      output is_last_round,
      input  out_valid,
      input  state_out
   );

   modport slave (
      input  in_valid,
      input  state_in,
      input  round_key,
      input  is_last_round,
      output out_valid,
      output state_out
   );
endinterface

// File: rtl/aes_enc_round.sv
// One AES-128 encryption round: SubBytes, ShiftRows, MixColumns (bypassed on
// the last round) and AddRoundKey, feeding a single output register.
module aes_enc_round (
   input  logic            clk,
   input  logic            rst,
   aes_enc_round_if.slave  bus
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by {02} in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0]   w_inByte    [16];
   logic [7:0]   w_subByte   [16];
   logic [7:0]   w_shiftByte [16];
   logic [7:0]   w_mixByte   [16];
   logic [7:0]   w_outByte   [16];
   logic [127:0] w_nextState;
   logic [127:0] r_stateOut;
   logic         r_outValid;

   // Byte k lives at row k%4, column k/4, most significant byte first.
   for (genvar k = 0; k < 16; k++) begin : g_sub
      assign w_inByte[k]  = bus.state_in[127-8*k -: 8];
      assign w_subByte[k] = SBOX[w_inByte[k]];
   end

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign w_shiftByte[r+4*c] = w_subByte[r+4*((c+r)%4)];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_shiftByte[4*c+0];
      assign w_a1 = w_shiftByte[4*c+1];
      assign w_a2 = w_shiftByte[4*c+2];
      assign w_a3 = w_shiftByte[4*c+3];
      assign w_mixByte[4*c+0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign w_mixByte[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign w_mixByte[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign w_mixByte[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
   end

   for (genvar k = 0; k < 16; k++) begin : g_key
      assign w_outByte[k] = (bus.is_last_round ? w_shiftByte[k] : w_mixByte[k])
                            ^ bus.round_key[127-8*k -: 8];
      assign w_nextState[127-8*k -: 8] = w_outByte[k];
   end

   // The state register only loads on a valid input, so idle cycles hold the
   // last result regardless of what the data inputs carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stateOut <= 128'h0;
         r_outValid <= 1'b0;
      end else begin
         r_outValid <= bus.in_valid;
         if (bus.in_valid) begin
            r_stateOut <= w_nextState;
         end
      end
   end

   assign bus.state_out = r_stateOut;
   assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_aes_enc_round.sv
// Self-checking bench for aes_enc_round: known FIPS-197 vectors plus random
// traffic against a matrix-level GF(2^8) reference model.
module tb_aes_enc_round;

   logic clk = 1'b0;
   logic rst = 1'b1;

   aes_enc_round_if bus ();

   aes_enc_round dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int compareCount  = 0;
   int mismatchCount = 0;

   logic [7:0]   sboxTab [256];
   logic [127:0] keySched [10];
   logic [127:0] expState;
   logic         expValid;
   logic [127:0] chainState;
   logic [127:0] rndState, rndKey;
   logic         rndValid, rndLast, rndReset;

   localparam logic [127:0] V3_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] V3_KEY  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] V3_OUT  = 128'h89d810e8855ace682d1843d8cb128fe4;
   localparam logic [127:0] V4_IN   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
   localparam logic [127:0] V4_KEY  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] V4_OUT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? (({x[6:0], 1'b0}) ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   function automatic logic [7:0] sboxCalc(input logic [7:0] b);
      logic [7:0] inv = 8'h00;
      logic [7:0] v;
      for (int x = 1; x < 256; x++) begin
         if (b != 8'h00 && gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
      end
      v = inv;
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] mixCoef(input int d);
      case (d)
         0:       return 8'h02;
         1:       return 8'h03;
         default: return 8'h01;
      endcase
   endfunction

   function automatic logic [127:0] refRound(input logic [127:0] st, input logic [127:0] key,
                                             input logic last);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   m [4][4];
      logic [127:0] res = 128'h0;
      for (int k = 0; k < 16; k++) s[k%4][k/4] = sboxTab[8'(st >> (120 - 8*k))];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            m[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) m[r][c] = m[r][c] ^ gmul(mixCoef((j - r + 4) % 4), t[j][c]);
         end
      for (int k = 0; k < 16; k++)
         res = (res << 8) | 128'(last ? t[k%4][k/4] : m[k%4][k/4]);
      return res ^ key;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Present inputs for one edge, then step just past it for sampling.
   task automatic applyStimulus(input logic rstIn, input logic valid, input logic [127:0] st,
                                input logic [127:0] key, input logic last);
      rst               = rstIn;
      bus.in_valid      = valid;
      bus.state_in      = st;
      bus.round_key     = key;
      bus.is_last_round = last;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid      = 1'b1;
      bus.state_in      = V3_IN;
      bus.round_key     = V3_KEY;
      bus.is_last_round = 1'b0;

      for (int i = 0; i < 256; i++) sboxTab[i] = sboxCalc(8'(i));
      keySched[0] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      keySched[1] = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      keySched[2] = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      keySched[3] = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      keySched[4] = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      keySched[5] = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      keySched[6] = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      keySched[7] = 128'h47438735a41c65b9e016baf4aebf7ad2;
      keySched[8] = 128'h549932d1f08557681093ed9cbe2c974e;
      keySched[9] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

      // Reset dominates a valid input, and nothing appears until new data.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b1, V3_IN, V3_KEY, 1'b0);
         checkOutput("reset_state", bus.state_out, 128'h0);
         checkOutput("reset_valid", 128'(bus.out_valid), 128'h0);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 128'hx, 128'hx, 1'bx);
         checkOutput("post_reset_state", bus.state_out, 128'h0);
         checkOutput("post_reset_valid", 128'(bus.out_valid), 128'h0);
      end

      applyStimulus(1'b0, 1'b1, 128'h0, 128'h0, 1'b0);
      checkOutput("zero_vec_state", bus.state_out, 128'h63636363636363636363636363636363);
      checkOutput("zero_vec_model", bus.state_out, refRound(128'h0, 128'h0, 1'b0));
      checkOutput("zero_vec_valid", 128'(bus.out_valid), 128'h1);
      applyStimulus(1'b0, 1'b0, 128'hx, 128'hx, 1'bx);
      checkOutput("idle_hold_state", bus.state_out, 128'h63636363636363636363636363636363);
      checkOutput("idle_valid", 128'(bus.out_valid), 128'h0);

      applyStimulus(1'b0, 1'b1, V3_IN, V3_KEY, 1'b0);
      checkOutput("fips_round1", bus.state_out, V3_OUT);
      applyStimulus(1'b0, 1'b0, 128'h0, 128'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, V4_IN, V4_KEY, 1'b1);
      checkOutput("fips_round10", bus.state_out, V4_OUT);
      applyStimulus(1'b0, 1'b0, 128'h0, 128'h0, 1'b0);

      // Full ten-round chain, feeding each result back.
      chainState = 128'h00112233445566778899aabbccddeeff ^ 128'h000102030405060708090a0b0c0d0e0f;
      for (int rd = 0; rd < 10; rd++) begin
         expState = refRound(chainState, keySched[rd], rd == 9);
         applyStimulus(1'b0, 1'b1, chainState, keySched[rd], rd == 9);
         checkOutput($sformatf("chain_round%0d", rd + 1), bus.state_out, expState);
         chainState = bus.state_out;
      end
      checkOutput("chain_final", chainState, V4_OUT);

      applyStimulus(1'b0, 1'b1, V3_IN, V3_KEY, 1'b0);
      checkOutput("b2b_first", bus.state_out, V3_OUT);
      checkOutput("b2b_first_valid", 128'(bus.out_valid), 128'h1);
      applyStimulus(1'b0, 1'b1, V4_IN, V4_KEY, 1'b1);
      checkOutput("b2b_second", bus.state_out, V4_OUT);
      checkOutput("b2b_second_valid", 128'(bus.out_valid), 128'h1);

      applyStimulus(1'b0, 1'b1, V3_IN, V3_KEY, 1'b0);
      checkOutput("mid_rst_first", bus.state_out, V3_OUT);
      applyStimulus(1'b1, 1'b1, V4_IN, V4_KEY, 1'b1);
      checkOutput("mid_rst_state", bus.state_out, 128'h0);
      checkOutput("mid_rst_valid", 128'(bus.out_valid), 128'h0);
      applyStimulus(1'b0, 1'b0, 128'hx, 128'hx, 1'bx);
      checkOutput("mid_rst_after", bus.state_out, 128'h0);

      // Random traffic with idle gaps and occasional resets.
      expState = 128'h0;
      expValid = 1'b0;
      for (int n = 0; n < 300; n++) begin
         rndState = {$urandom, $urandom, $urandom, $urandom};
         rndKey   = {$urandom, $urandom, $urandom, $urandom};
         rndValid = ($urandom_range(0, 9) < 7);
         rndLast  = 1'($urandom_range(0, 1));
         rndReset = ($urandom_range(0, 19) == 0);
         if (rndReset) begin
            expState = 128'h0;
            expValid = 1'b0;
         end else begin
            expValid = rndValid;
            if (rndValid) expState = refRound(rndState, rndKey, rndLast);
         end
         applyStimulus(rndReset, rndValid, rndState, rndKey, rndLast);
         checkOutput("rand_state", bus.state_out, expState);
         checkOutput("rand_valid", 128'(bus.out_valid), 128'(expValid));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/aes_enc_round.md
Name: aes_enc_round

Overview:
- One AES-128 encryption round (FIPS-197): SubBytes, ShiftRows, MixColumns (skipped in final round), AddRoundKey, with a single registered output stage.
- Driven by an external round sequencer: the initial whitening XOR (plaintext ^ key0) is done outside the block.
- The sequencer feeds each output back as the next round's input, with rounds 1..10 keys supplied externally. No key expansion inside.

Parameters:
- None. The data width is fixed at 128 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies state_in, round_key and is_last_round for one cycle.
- state_in  input  128  round input state.
- round_key  input  128  round key for this round.
- is_last_round  input  1  1 means skip MixColumns (round 10).
- out_valid  output  1  state_out holds a new result.
- state_out  output  128  registered round result.

Behaviour:
- Byte mapping:
  - state_in[127:120] is byte 0; byte k = state_in[127-8k -: 8].
  - Column-major: byte k sits at row k%4, column k/4. This matches the FIPS-197 hex string order.
  - The same mapping applies to round_key and state_out.
- SubBytes: standard forward AES S-box on all 16 bytes. 16 parallel lookups; a ROM function or case table is acceptable.
- ShiftRows: row r rotated left by r bytes, so new(r,c) = old(r,(c+r) mod 4).
- MixColumns: each column multiplied by the circulant matrix [02 03 01 01] over GF(2^8).
  - Reduction polynomial 0x11B.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0x00).
  - Bypassed entirely when is_last_round=1.
- AddRoundKey: 128-bit XOR with round_key, applied after MixColumns or its bypass.
- Datapath is combinational from inputs to the register D input. There are no intermediate registers.
- Latency is 1 cycle:
  - in_valid sampled high at edge N gives state_out = result and out_valid=1 after edge N.
  - Throughput is one round per cycle; back-to-back in_valid is allowed with independent results.
- in_valid low at an edge: out_valid goes to 0 and state_out holds its previous value.
- Reset: when rst=1 at an edge, state_out <= 128'h0 and out_valid <= 0.
  - Reset overrides a simultaneous in_valid; that input is dropped.
  - A reset between rounds discards the in-flight result. The sequencer must restart from the whitening step.
- is_last_round is sampled only with in_valid and affects only that transaction.
- Inputs that are X or Z while in_valid=0 must not affect state_out.

Test Plan:
1. Reset: hold rst=1 with in_valid=1 for 2 cycles -> state_out=0, out_valid=0. Release rst -> both still 0 until the next valid input.
2. Zero vector: state_in=0, key=0, is_last_round=0, in_valid pulse -> one cycle later state_out=63636363636363636363636363636363, out_valid=1. The next cycle, with in_valid=0 -> out_valid=0, state_out unchanged.
3. FIPS-197 C.1 round 1: state_in=00102030405060708090a0b0c0d0e0f0, key=d6aa74fdd2af72fadaa678f1d6ab76fe, last=0 -> state_out=89d810e8855ace682d1843d8cb128fe4.
4. FIPS-197 C.1 round 10: state_in=bd6e7c3df2b5779e0b61216e8b10b689, key=13111d7fe3944a17f307a78b4d2b30c5, last=1 -> state_out=69c4e0d86a7b0430d8cdb78070b4c55a.
5. Full chain: start from 00112233445566778899aabbccddeeff ^ 000102030405060708090a0b0c0d0e0f.
   - Iterate 10 rounds with the FIPS-197 C.1 key schedule: d6aa74fd... b692cf0b... b6ff744e... 47f7f7bc... 3caaa3e8... 5e390f7d... 14f9701a... 47438735... 549932d1... 13111d7f...
   - Set last=1 on round 10.
   - Feed each output back as the next input -> final output 69c4e0d86a7b0430d8cdb78070b4c55a.
6. Back-to-back and mid-stream reset:
   - Present vector 3, then vector 4, on consecutive cycles -> correct outputs on consecutive cycles, out_valid high for 2 cycles.
   - Repeat with rst asserted together with the second input -> second result dropped, state_out=0.
